tx_byte_scheduler: RTL and testbench

- Sits in the REF_CLK domain between the register file read port, the ALU result port and the write side of the UART TX async FIFO.
- Captures single-cycle result pulses from both sources into one-entry holding buffers.
- Arbitrates between the two sources and serialises the 16-bit ALU result into two bytes.
- Pushes one byte per cycle into the FIFO, never while FIFO_FULL is high.

---
 rtl/tx_byte_scheduler_if.sv | 20 ++
 rtl/tx_byte_scheduler.sv | 83 ++++++++
 tb/tb_tx_byte_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/tx_byte_scheduler_if.sv
// tx_byte_scheduler_if: source pulses and FIFO write side seen by the TX byte scheduler
interface tx_byte_scheduler_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0]   RF_RdData;
  logic                    RF_RdData_VLD;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
  logic                    FIFO_FULL;
  logic [DATA_WIDTH-1:0]   TX_DATA;
  logic                    TX_VLD;
  logic                    SCHED_BUSY;
  logic                    SCHED_OVF;
  modport master (
    output RF_RdData, RF_RdData_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
    input  TX_DATA, TX_VLD, SCHED_BUSY, SCHED_OVF
  );
  modport slave (
    input  RF_RdData, RF_RdData_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
    output TX_DATA, TX_VLD, SCHED_BUSY, SCHED_OVF
  );
endinterface

// File: rtl/tx_byte_scheduler.sv
// tx_byte_scheduler: buffers RF/ALU results and pushes them bytewise into the TX FIFO (TX_SCHED_MSB_FIRST_EN: ALU high byte first)
module tx_byte_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int FIXED_PRIO = 0
) (
  input logic CLK,
  input logic RST,
  tx_byte_scheduler_if.slave bus
);
  localparam int W = DATA_WIDTH;
  typedef enum logic {IDLE, ALU_HI} state_t;
  state_t state, state_n;
  logic rf_pend, alu_pend, last_rf;
  logic rf_pend_n, alu_pend_n, last_rf_n;
  logic rf_free, alu_free, rf_take, alu_take, push, grant_rf, ovf_n;
  logic [W-1:0] rf_buf, push_data, alu_first, alu_second;
  logic [2*W-1:0] alu_buf;
`ifdef TX_SCHED_MSB_FIRST_EN
  assign alu_first  = alu_buf[2*W-1:W];
  assign alu_second = alu_buf[W-1:0];
`else
  assign alu_first  = alu_buf[W-1:0];
  assign alu_second = alu_buf[2*W-1:W];
`endif
  // last_rf low means ALU was granted last, so RF wins the next tie
  assign grant_rf = rf_pend && (!alu_pend || FIXED_PRIO != 0 || !last_rf);
  always_comb begin
    state_n   = state;
    push      = 1'b0;
    push_data = rf_buf;
    rf_free   = 1'b0;
    alu_free  = 1'b0;
    last_rf_n = last_rf;
    if (state == ALU_HI) begin
      if (!bus.FIFO_FULL) begin
        push      = 1'b1;
        push_data = alu_second;
        alu_free  = 1'b1;
        state_n   = IDLE;
      end
    end else if (!bus.FIFO_FULL && (rf_pend || alu_pend)) begin
      push = 1'b1;
      if (grant_rf) begin
        rf_free   = 1'b1;
        last_rf_n = 1'b1;
      end else begin
        push_data = alu_first;
        last_rf_n = 1'b0;
        state_n   = ALU_HI;
      end
    end
    rf_take    = bus.RF_RdData_VLD && (!rf_pend || rf_free);
    alu_take   = bus.ALU_OUT_VLD && (!alu_pend || alu_free);
    rf_pend_n  = bus.RF_RdData_VLD || (rf_pend && !rf_free);
    alu_pend_n = bus.ALU_OUT_VLD || (alu_pend && !alu_free);
    ovf_n      = (bus.RF_RdData_VLD && !rf_take) || (bus.ALU_OUT_VLD && !alu_take);
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      rf_pend        <= 1'b0;
      alu_pend       <= 1'b0;
      last_rf        <= 1'b0;
      rf_buf         <= '0;
      alu_buf        <= '0;
      bus.TX_DATA    <= '0;
      bus.TX_VLD     <= 1'b0;
      bus.SCHED_BUSY <= 1'b0;
      bus.SCHED_OVF  <= 1'b0;
    end else begin
      state          <= state_n;
      rf_pend        <= rf_pend_n;
      alu_pend       <= alu_pend_n;
      last_rf        <= last_rf_n;
      if (rf_take) rf_buf <= bus.RF_RdData;
      if (alu_take) alu_buf <= bus.ALU_OUT;
      if (push) bus.TX_DATA <= push_data;
      bus.TX_VLD     <= push;
      bus.SCHED_BUSY <= rf_pend_n || alu_pend_n || state_n == ALU_HI;
      bus.SCHED_OVF  <= ovf_n;
    end
  end
endmodule

// File: tb/tb_tx_byte_scheduler.sv
// tb_tx_byte_scheduler: scoreboard bench for round-robin and fixed-priority builds driven in lockstep
module tb_tx_byte_scheduler;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;
  tx_byte_scheduler_if #(.DATA_WIDTH(8)) bus ();
  tx_byte_scheduler_if #(.DATA_WIDTH(8)) bus_fp ();
  assign bus_fp.RF_RdData     = bus.RF_RdData;
  assign bus_fp.RF_RdData_VLD = bus.RF_RdData_VLD;
  assign bus_fp.ALU_OUT       = bus.ALU_OUT;
  assign bus_fp.ALU_OUT_VLD   = bus.ALU_OUT_VLD;
  assign bus_fp.FIFO_FULL     = bus.FIFO_FULL;
  tx_byte_scheduler #(.DATA_WIDTH(8), .FIXED_PRIO(0)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
  tx_byte_scheduler #(.DATA_WIDTH(8), .FIXED_PRIO(1)) dut_fp (.CLK(CLK), .RST(RST), .bus(bus_fp.slave));
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];
  logic [7:0] qf[$];
  logic [7:0] exp_rr, exp_fp;
  logic [15:0] o;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] order(input logic [15:0] a);
`ifdef TX_SCHED_MSB_FIRST_EN
    return a;
`else
    return {a[7:0], a[15:8]};
`endif
  endfunction
  task automatic exp_b(input logic [7:0] d);
    q.push_back(d);
    qf.push_back(d);
  endtask
  task automatic exp_alu(input logic [15:0] a);
    logic [15:0] s;
    s = order(a);
    exp_b(s[15:8]);
    exp_b(s[7:0]);
  endtask
  task automatic drive(input logic rv, input logic [7:0] rd, input logic av, input logic [15:0] ad);
    bus.RF_RdData_VLD = rv;
    bus.RF_RdData     = rd;
    bus.ALU_OUT_VLD   = av;
    bus.ALU_OUT       = ad;
    @(negedge CLK);
    bus.RF_RdData_VLD = 1'b0;
    bus.ALU_OUT_VLD   = 1'b0;
  endtask
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      ok = q.size() == 0 && qf.size() == 0 && !bus.SCHED_BUSY && !bus_fp.SCHED_BUSY && !bus.TX_VLD && !bus_fp.TX_VLD;
    end
    if (!ok) check("idle_timeout", 16'd0, 16'd1);
  endtask
  always @(negedge CLK) begin
    if (bus.TX_VLD) begin
      if (q.size() == 0) check("rr_extra_byte", 16'd1, 16'd0);
      else begin
        exp_rr = q.pop_front();
        check("rr_byte", {8'h0, bus.TX_DATA}, {8'h0, exp_rr});
      end
    end
    if (bus_fp.TX_VLD) begin
      if (qf.size() == 0) check("fp_extra_byte", 16'd1, 16'd0);
      else begin
        exp_fp = qf.pop_front();
        check("fp_byte", {8'h0, bus_fp.TX_DATA}, {8'h0, exp_fp});
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    bus.RF_RdData = '0;
    bus.RF_RdData_VLD = 1'b0;
    bus.ALU_OUT = '0;
    bus.ALU_OUT_VLD = 1'b0;
    bus.FIFO_FULL = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_data", {8'h0, bus.TX_DATA}, 16'h0);
    check("rst_vld", {15'h0, bus.TX_VLD}, 16'h0);
    check("rst_busy", {15'h0, bus.SCHED_BUSY}, 16'h0);
    check("rst_ovf", {15'h0, bus.SCHED_OVF}, 16'h0);
    RST = 1'b1;
    @(negedge CLK);
    exp_b(8'hA5);
    drive(1'b1, 8'hA5, 1'b0, 16'h0);
    check("rf_lat0", {15'h0, bus.TX_VLD}, 16'h0);
    @(negedge CLK);
    check("rf_lat1", {15'h0, bus.TX_VLD}, 16'h1);
    check("rf_data", {8'h0, bus.TX_DATA}, 16'h00A5);
    @(negedge CLK);
    check("rf_once", {15'h0, bus.TX_VLD}, 16'h0);
    check("rf_hold", {8'h0, bus.TX_DATA}, 16'h00A5);
    check("rf_busy_drop", {15'h0, bus.SCHED_BUSY}, 16'h0);
    wait_idle();
    exp_alu(16'h1234);
    drive(1'b0, 8'h0, 1'b1, 16'h1234);
    @(negedge CLK);
    check("alu_first_vld", {15'h0, bus.TX_VLD}, 16'h1);
    @(negedge CLK);
    check("alu_second_vld", {15'h0, bus.TX_VLD}, 16'h1);
    @(negedge CLK);
    check("alu_done", {15'h0, bus.TX_VLD}, 16'h0);
    wait_idle();
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      exp_b(8'h11);
      exp_alu(16'hBEEF);
      drive(1'b1, 8'h11, 1'b1, 16'hBEEF);
      wait_idle();
    end
    exp_b(8'h33);
    drive(1'b1, 8'h33, 1'b0, 16'h0);
    wait_idle();
    o = order(16'h5566);
    q.push_back(o[15:8]);
    q.push_back(o[7:0]);
    q.push_back(8'h44);
    qf.push_back(8'h44);
    qf.push_back(o[15:8]);
    qf.push_back(o[7:0]);
    drive(1'b1, 8'h44, 1'b1, 16'h5566);
    wait_idle();
    exp_alu(16'hCAFE);
    drive(1'b0, 8'h0, 1'b1, 16'hCAFE);
    @(negedge CLK);
    check("stall_first", {15'h0, bus.TX_VLD}, 16'h1);
    bus.FIFO_FULL = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("stall_vld", {15'h0, bus.TX_VLD}, 16'h0);
      check("stall_busy", {15'h0, bus.SCHED_BUSY}, 16'h1);
    end
    bus.FIFO_FULL = 1'b0;
    @(negedge CLK);
    check("stall_second", {15'h0, bus.TX_VLD}, 16'h1);
    @(negedge CLK);
    check("stall_done", {15'h0, bus.TX_VLD}, 16'h0);
    wait_idle();
    bus.FIFO_FULL = 1'b1;
    exp_b(8'h01);
    bus.RF_RdData_VLD = 1'b1;
    bus.RF_RdData = 8'h01;
    @(negedge CLK);
    bus.RF_RdData = 8'h02;
    check("ovf_first", {15'h0, bus.SCHED_OVF}, 16'h0);
    @(negedge CLK);
    bus.RF_RdData_VLD = 1'b0;
    check("ovf_pulse", {15'h0, bus.SCHED_OVF}, 16'h1);
    check("ovf_pulse_fp", {15'h0, bus_fp.SCHED_OVF}, 16'h1);
    @(negedge CLK);
    check("ovf_once", {15'h0, bus.SCHED_OVF}, 16'h0);
    bus.FIFO_FULL = 1'b0;
    wait_idle();
    o = order(16'h5678);
    exp_b(o[15:8]);
    drive(1'b0, 8'h0, 1'b1, 16'h5678);
    @(negedge CLK);
    check("mid_first", {15'h0, bus.TX_VLD}, 16'h1);
    #2 RST = 1'b0;
    #1;
    check("mid_rst_vld", {15'h0, bus.TX_VLD}, 16'h0);
    check("mid_rst_data", {8'h0, bus.TX_DATA}, 16'h0);
    check("mid_rst_busy", {15'h0, bus.SCHED_BUSY}, 16'h0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      check("post_rst_vld", {15'h0, bus.TX_VLD}, 16'h0);
      check("post_rst_busy", {15'h0, bus.SCHED_BUSY}, 16'h0);
    end
    check("rr_left", 16'(q.size()), 16'd0);
    check("fp_left", 16'(qf.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
